// File: rtl/lemmings_track.sv
// Position tracker for a Lemmings-style walker: moves pos one step per strobe and
// pulses bump_left/bump_right when a step is blocked by a wall. Optional
// saturating bump counter is built when LEMMINGS_TRACK_BUMP_COUNT_EN is defined.
module lemmings_track #(
    parameter int unsigned POS_W   = 4,
    parameter int unsigned WALL_LO = 0,
    parameter int unsigned WALL_HI = 15,
    parameter int unsigned START   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             walk_left,
    input  logic             walk_right,
    output logic             bump_left,
    output logic             bump_right,
    output logic [POS_W-1:0] pos,
    output logic             at_wall
`ifdef LEMMINGS_TRACK_BUMP_COUNT_EN
    ,
    output logic [7:0]       bump_count
`endif
);

    localparam logic [POS_W-1:0] LO    = POS_W'(WALL_LO);
    localparam logic [POS_W-1:0] HI    = POS_W'(WALL_HI);
    localparam logic [POS_W-1:0] START_POS = POS_W'(START);

    if (!((WALL_LO <= START) && (START <= WALL_HI) &&
          (longint'(WALL_HI) <= ((longint'(1) << POS_W) - 1)))) begin : g_bad_params
        $error("lemmings_track: need WALL_LO <= START <= WALL_HI <= 2**POS_W-1");
    end

    logic [POS_W-1:0] pos_q, pos_d;
    logic             bump_left_q, bump_left_d;
    logic             bump_right_q, bump_right_d;
    logic             go_left, go_right;

    // Equal direction bits are treated as idle, so both bumps can never fire together.
    assign go_left  = step && walk_left && !walk_right;
    assign go_right = step && walk_right && !walk_left;

    always_comb begin
        pos_d        = pos_q;
        bump_left_d  = 1'b0;
        bump_right_d = 1'b0;
        if (go_left) begin
            if (pos_q > LO) begin
                pos_d = pos_q - POS_W'(1);
            end else begin
                bump_left_d = 1'b1;
            end
        end else if (go_right) begin
            if (pos_q < HI) begin
                pos_d = pos_q + POS_W'(1);
            end else begin
                bump_right_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q        <= START_POS;
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            bump_left_q  <= bump_left_d;
            bump_right_q <= bump_right_d;
        end
    end

    assign pos        = pos_q;
    assign bump_left  = bump_left_q;
    assign bump_right = bump_right_q;
    assign at_wall    = (pos_q == LO) || (pos_q == HI);

`ifdef LEMMINGS_TRACK_BUMP_COUNT_EN
    logic [7:0] bump_count_q;

    // Counts cycles on which a bump output is high, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            bump_count_q <= 8'd0;
        end else if ((bump_left_q || bump_right_q) && (bump_count_q != 8'hff)) begin
            bump_count_q <= bump_count_q + 8'd1;
        end
    end

    assign bump_count = bump_count_q;
`endif

endmodule

// File: tb/tb_lemmings_track.sv
// Directed self-checking bench for lemmings_track, including a closed loop with
// a walker model and a single-position track instance.
module tb_lemmings_track;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step = 1'b0;
    logic       walk_left = 1'b0;
    logic       walk_right = 1'b0;
    logic       bump_left, bump_right, at_wall;
    logic [3:0] pos;
    logic       p_bump_left, p_bump_right, p_at_wall;
    logic [3:0] p_pos;
`ifdef LEMMINGS_TRACK_BUMP_COUNT_EN
    logic [7:0] bump_count, p_bump_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lemmings_track #(.POS_W(4), .WALL_LO(0), .WALL_HI(15), .START(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .pos        (pos),
        .at_wall    (at_wall)
`ifdef LEMMINGS_TRACK_BUMP_COUNT_EN
        ,
        .bump_count (bump_count)
`endif
    );

    lemmings_track #(.POS_W(4), .WALL_LO(5), .WALL_HI(5), .START(5)) u_pt (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .bump_left  (p_bump_left),
        .bump_right (p_bump_right),
        .pos        (p_pos),
        .at_wall    (p_at_wall)
`ifdef LEMMINGS_TRACK_BUMP_COUNT_EN
        ,
        .bump_count (p_bump_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; step = 1'b0; walk_left = 1'b0; walk_right = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step = 1'b1; walk_left = 1'b1; walk_right = 1'b0;
        tick();
        reset = 1'b0; step = 1'b0; walk_left = 1'b0;
        n_cmp++; if (pos !== 4'd8) begin n_bad++; $display("FAIL reset_pos: got %0d want 8", pos); end
        n_cmp++; if (bump_left !== 1'b0) begin n_bad++; $display("FAIL reset_bl: got %b want 0", bump_left); end
        n_cmp++; if (bump_right !== 1'b0) begin n_bad++; $display("FAIL reset_br: got %b want 0", bump_right); end
        n_cmp++; if (at_wall !== 1'b0) begin n_bad++; $display("FAIL reset_at_wall: got %b want 0", at_wall); end
        tick();
        n_cmp++; if (pos !== 4'd8) begin n_bad++; $display("FAIL idle_hold: got %0d want 8", pos); end
    endtask

    task automatic test_left_walk();
        do_reset();
        step = 1'b1; walk_left = 1'b1; walk_right = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++;
            if (pos !== 4'(8 - i) || bump_left !== 1'b0) begin
                n_bad++;
                $display("FAIL left_walk[%0d]: got pos=%0d bl=%b want pos=%0d bl=0", i, pos, bump_left, 8 - i);
            end
        end
        n_cmp++; if (at_wall !== 1'b1) begin n_bad++; $display("FAIL left_at_wall: got %b want 1", at_wall); end
        tick();
        n_cmp++;
        if (bump_left !== 1'b1 || bump_right !== 1'b0 || pos !== 4'd0) begin
            n_bad++;
            $display("FAIL left_bump: got bl=%b br=%b pos=%0d want 1 0 0", bump_left, bump_right, pos);
        end
        step = 1'b0;
        tick();
        n_cmp++;
        if (bump_left !== 1'b0 || pos !== 4'd0) begin
            n_bad++;
            $display("FAIL left_bump_clear: got bl=%b pos=%0d want 0 0", bump_left, pos);
        end
    endtask

    task automatic test_right_wall();
        do_reset();
        step = 1'b1; walk_right = 1'b1; walk_left = 1'b0;
        repeat (6) tick();
        n_cmp++; if (pos !== 4'd14) begin n_bad++; $display("FAIL right_pre: got %0d want 14", pos); end
        tick();
        n_cmp++;
        if (pos !== 4'd15 || bump_right !== 1'b0 || at_wall !== 1'b1) begin
            n_bad++;
            $display("FAIL right_reach: got pos=%0d br=%b aw=%b want 15 0 1", pos, bump_right, at_wall);
        end
        tick();
        n_cmp++;
        if (pos !== 4'd15 || bump_right !== 1'b1 || bump_left !== 1'b0) begin
            n_bad++;
            $display("FAIL right_bump: got pos=%0d br=%b bl=%b want 15 1 0", pos, bump_right, bump_left);
        end
        // Blocked steps keep re-pulsing the bump.
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bump_right !== 1'b1 || pos !== 4'd15) begin
                n_bad++;
                $display("FAIL right_repulse[%0d]: got br=%b pos=%0d want 1 15", i, bump_right, pos);
            end
        end
        step = 1'b0;
        tick();
        n_cmp++; if (bump_right !== 1'b0) begin n_bad++; $display("FAIL right_clear: got %b want 0", bump_right); end
        // Direction held but no strobe: nothing moves.
        walk_right = 1'b0; walk_left = 1'b1;
        tick();
        n_cmp++; if (pos !== 4'd15) begin n_bad++; $display("FAIL nostep_hold: got %0d want 15", pos); end
    endtask

    task automatic test_illegal_dir();
        do_reset();
        step = 1'b1; walk_left = 1'b1; walk_right = 1'b1;
        tick();
        n_cmp++; if (pos !== 4'd8) begin n_bad++; $display("FAIL both_mid: got %0d want 8", pos); end
        walk_right = 1'b0;
        repeat (8) tick();
        walk_right = 1'b1;
        tick();
        n_cmp++;
        if (pos !== 4'd0 || bump_left !== 1'b0 || bump_right !== 1'b0) begin
            n_bad++;
            $display("FAIL both_at_wall: got pos=%0d bl=%b br=%b want 0 0 0", pos, bump_left, bump_right);
        end
        walk_left = 1'b0; walk_right = 1'b0;
        tick();
        n_cmp++;
        if (pos !== 4'd0 || bump_left !== 1'b0) begin
            n_bad++;
            $display("FAIL none_at_wall: got pos=%0d bl=%b want 0 0", pos, bump_left);
        end
        step = 1'b0;
    endtask

    task automatic test_closed_loop();
        bit dir_right;
        bit prev_bl, prev_br;
        int rise_l, rise_r;
        bit first_left;
        do_reset();
        dir_right = 1'b0; prev_bl = 1'b0; prev_br = 1'b0;
        rise_l = 0; rise_r = 0; first_left = 1'b0;
        step = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            walk_left = !dir_right; walk_right = dir_right;
            tick();
            // Moore walker reverses on the edge where it saw the bump.
            if (!dir_right && prev_bl) dir_right = 1'b1;
            else if (dir_right && prev_br) dir_right = 1'b0;
            if (bump_left && !prev_bl) begin
                if (rise_l + rise_r == 0) first_left = 1'b1;
                rise_l++;
            end
            if (bump_right && !prev_br) rise_r++;
            n_cmp++;
            if ((bump_left && bump_right) || pos > 4'd15) begin
                n_bad++;
                $display("FAIL loop_inv[%0d]: got bl=%b br=%b pos=%0d", c, bump_left, bump_right, pos);
            end
            prev_bl = bump_left; prev_br = bump_right;
        end
        n_cmp++; if (pos !== 4'd2) begin n_bad++; $display("FAIL loop_pos: got %0d want 2", pos); end
        n_cmp++;
        if (rise_l != 1 || rise_r != 1 || !first_left) begin
            n_bad++;
            $display("FAIL loop_pulses: got left=%0d right=%0d first_left=%b want 1 1 1", rise_l, rise_r, first_left);
        end
        step = 1'b0; walk_left = 1'b0; walk_right = 1'b0;
    endtask

    task automatic test_reset_mid_bump();
        do_reset();
        step = 1'b1; walk_left = 1'b1; walk_right = 1'b0;
        repeat (12) tick();
        n_cmp++;
        if (bump_left !== 1'b1) begin n_bad++; $display("FAIL mid_pre_bl: got %b want 1", bump_left); end
`ifdef LEMMINGS_TRACK_BUMP_COUNT_EN
        n_cmp++; if (bump_count !== 8'd3) begin n_bad++; $display("FAIL mid_pre_cnt: got %0d want 3", bump_count); end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0; step = 1'b0;
        n_cmp++;
        if (bump_left !== 1'b0 || pos !== 4'd8) begin
            n_bad++;
            $display("FAIL mid_reset: got bl=%b pos=%0d want 0 8", bump_left, pos);
        end
`ifdef LEMMINGS_TRACK_BUMP_COUNT_EN
        n_cmp++; if (bump_count !== 8'd0) begin n_bad++; $display("FAIL mid_cnt_clr: got %0d want 0", bump_count); end
        step = 1'b1;
        repeat (8 + 301) tick();
        n_cmp++; if (bump_count !== 8'd255) begin n_bad++; $display("FAIL cnt_sat: got %0d want 255", bump_count); end
        step = 1'b0;
`endif
    endtask

    task automatic test_single_pos();
        do_reset();
        n_cmp++;
        if (p_pos !== 4'd5 || p_at_wall !== 1'b1) begin
            n_bad++;
            $display("FAIL pt_reset: got pos=%0d aw=%b want 5 1", p_pos, p_at_wall);
        end
        step = 1'b1; walk_left = 1'b1; walk_right = 1'b0;
        tick();
        n_cmp++;
        if (p_bump_left !== 1'b1 || p_bump_right !== 1'b0 || p_pos !== 4'd5) begin
            n_bad++;
            $display("FAIL pt_left: got bl=%b br=%b pos=%0d want 1 0 5", p_bump_left, p_bump_right, p_pos);
        end
        walk_left = 1'b0; walk_right = 1'b1;
        tick();
        n_cmp++;
        if (p_bump_right !== 1'b1 || p_bump_left !== 1'b0 || p_pos !== 4'd5) begin
            n_bad++;
            $display("FAIL pt_right: got bl=%b br=%b pos=%0d want 0 1 5", p_bump_left, p_bump_right, p_pos);
        end
        step = 1'b0; walk_right = 1'b0;
    endtask

    initial begin
        test_reset();
        test_left_walk();
        test_right_wall();
        test_illegal_dir();
        test_closed_loop();
        test_reset_mid_bump();
        test_single_pos();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
